// File: rtl/pipeline_seq_ctrl.sv
// rtl/pipeline_seq_ctrl.sv - debug run/step/stop sequencer and stall/flush control for a 5-stage pipeline
module pipeline_seq_ctrl #(
    parameter int CNT_SZ = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_step,
    input  logic              i_stop,
    input  logic              i_halt_wb,
    input  logic              i_load_use,
    output logic              o_pc_enable,
    output logic              o_if_id_enable,
    output logic              o_id_ex_flush,
    output logic              o_pipe_enable,
    output logic [1:0]        o_state,
    output logic              o_halted,
    output logic              o_step_done,
    output logic [CNT_SZ-1:0] o_cycle_count,
    output logic [CNT_SZ-1:0] o_step_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;

    localparam logic [CNT_SZ-1:0] CNT_ONE = {{(CNT_SZ-1){1'b0}}, 1'b1};
    localparam logic [CNT_SZ-1:0] CNT_MAX = {CNT_SZ{1'b1}};

    state_t state_q;
    state_t state_d;
    logic   active;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt at WB wins over stop; STEP always leaves after one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_stop) begin
                    state_d = IDLE;
                end else if (i_run) begin
                    state_d = RUN;
                end else if (i_step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (i_halt_wb) begin
                    state_d = HALTED;
                end else if (i_stop) begin
                    state_d = IDLE;
                end
            end
            STEP:    state_d = i_halt_wb ? HALTED : IDLE;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // A halt seen at MEM/WB freezes everything in the same cycle so it is never overwritten.
    always_comb begin
        active         = ((state_q == RUN) || (state_q == STEP)) && !i_halt_wb;
        o_pc_enable    = active && !i_load_use;
        o_if_id_enable = active && !i_load_use;
        o_pipe_enable  = active;
        o_id_ex_flush  = active && i_load_use;
    end

    assign o_state = state_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_cycle_count <= '0;
            o_step_count  <= '0;
            o_step_done   <= 1'b0;
            o_halted      <= 1'b0;
        end else begin
            if (active && (o_cycle_count != CNT_MAX)) begin
                o_cycle_count <= o_cycle_count + CNT_ONE;
            end
            if (state_q == STEP) begin
                o_step_count <= o_step_count + CNT_ONE;
            end
            o_step_done <= (state_q == STEP);
            o_halted    <= (state_d == HALTED);
        end
    end

endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
// tb/tb_pipeline_seq_ctrl.sv - self-checking bench for pipeline_seq_ctrl
module tb_pipeline_seq_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0, step = 1'b0, stop = 1'b0, halt_wb = 1'b0, load_use = 1'b0;

    logic        b_pc_en, b_ifid_en, b_flush, b_pipe_en, b_halted, b_done;
    logic [1:0]  b_state;
    logic [31:0] b_cycles, b_steps;
    logic        s_pc_en, s_ifid_en, s_flush, s_pipe_en, s_halted, s_done;
    logic [1:0]  s_state;
    logic [3:0]  s_cycles, s_steps;

    int n_vec = 0;
    int n_err = 0;
    int en_cnt = 0, done_cnt = 0, stall_cnt = 0;

    // Model: plain mode flags and unbounded counters
    bit     m_running = 0, m_stepping = 0, m_halted = 0, m_done = 0;
    longint m_cycles = 0, m_steps = 0;

    always #5 clk = ~clk;

    pipeline_seq_ctrl #(.CNT_SZ(32)) dut_big (
        .i_clk(clk), .i_reset(reset), .i_run(run), .i_step(step), .i_stop(stop),
        .i_halt_wb(halt_wb), .i_load_use(load_use),
        .o_pc_enable(b_pc_en), .o_if_id_enable(b_ifid_en), .o_id_ex_flush(b_flush),
        .o_pipe_enable(b_pipe_en), .o_state(b_state), .o_halted(b_halted),
        .o_step_done(b_done), .o_cycle_count(b_cycles), .o_step_count(b_steps)
    );

    pipeline_seq_ctrl #(.CNT_SZ(4)) dut_small (
        .i_clk(clk), .i_reset(reset), .i_run(run), .i_step(step), .i_stop(stop),
        .i_halt_wb(halt_wb), .i_load_use(load_use),
        .o_pc_enable(s_pc_en), .o_if_id_enable(s_ifid_en), .o_id_ex_flush(s_flush),
        .o_pipe_enable(s_pipe_en), .o_state(s_state), .o_halted(s_halted),
        .o_step_done(s_done), .o_cycle_count(s_cycles), .o_step_count(s_steps)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_state();
        if (m_halted) return 2'b11;
        if (m_stepping) return 2'b10;
        if (m_running) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit advancing();
        return (m_running || m_stepping) && !halt_wb;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_running = 0; m_stepping = 0; m_halted = 0; m_done = 0;
            m_cycles = 0; m_steps = 0;
        end else begin
            if (advancing()) m_cycles++;
            m_done = m_stepping;
            if (m_stepping) m_steps++;
            if (m_halted) begin
            end else if (m_stepping) begin
                m_stepping = 0;
                m_halted   = halt_wb;
            end else if (m_running) begin
                if (halt_wb) begin
                    m_running = 0;
                    m_halted  = 1;
                end else if (stop) begin
                    m_running = 0;
                end
            end else if (!stop) begin
                if (run) m_running = 1;
                else if (step) m_stepping = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("state", b_state, exp_state());
        check("pc_enable", b_pc_en, advancing() && !load_use);
        check("if_id_enable", b_ifid_en, advancing() && !load_use);
        check("pipe_enable", b_pipe_en, advancing());
        check("id_ex_flush", b_flush, advancing() && load_use);
        check("halted", b_halted, m_halted);
        check("step_done", b_done, m_done);
        check("cycle_count", b_cycles, m_cycles & 64'hFFFF_FFFF);
        check("step_count", b_steps, m_steps & 64'hFFFF_FFFF);
        check("small_state", s_state, exp_state());
        check("small_pipe_enable", s_pipe_en, advancing());
        check("small_cycle_sat", s_cycles, (m_cycles > 15) ? 15 : m_cycles);
        check("small_step_wrap", s_steps, m_steps % 16);
        if (b_pipe_en) en_cnt++;
        if (b_done) done_cnt++;
        if (b_flush && b_pipe_en && !b_pc_en && !b_ifid_en) stall_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        en_cnt = 0; done_cnt = 0; stall_cnt = 0;
    endtask

    initial begin
        #1 reset = 1'b0;
        tick();
        check("reset_state", b_state, 0);
        check("reset_cycles", b_cycles, 0);
        check("reset_pc_en", b_pc_en, 0);
        tick();
        reset = 1'b1;
        en_cnt = 0; done_cnt = 0; stall_cnt = 0;

        // run then stop: ten enabled cycles
        run = 1; tick(); run = 0;
        repeat (9) tick();
        stop = 1; tick(); stop = 0;
        check("run_stop_en_cycles", en_cnt, 10);
        check("run_stop_state", b_state, 0);
        check("run_stop_cycles", b_cycles, 10);

        // three single steps with gaps
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step = 1; tick(); step = 0;
            tick(); tick();
        end
        check("step3_en_cycles", en_cnt, 3);
        check("step3_done_pulses", done_cnt, 3);
        check("step3_step_count", b_steps, 3);
        check("step3_cycle_count", b_cycles, 3);

        // halt while running
        do_reset();
        run = 1; tick(); run = 0;
        tick();
        halt_wb = 1; #1;
        check("halt_same_cycle_pc_en", b_pc_en, 0);
        check("halt_same_cycle_pipe_en", b_pipe_en, 0);
        tick(); halt_wb = 0;
        check("halt_o_halted", b_halted, 1);
        check("halt_state", b_state, 3);
        en_cnt = 0;
        run = 1; tick(); run = 0;
        step = 1; tick(); step = 0;
        tick(); tick();
        check("halt_no_enable", en_cnt, 0);
        check("halt_cycles", b_cycles, 1);

        // step ending in halt still counts the step
        do_reset();
        step = 1; tick(); step = 0;
        halt_wb = 1; tick(); halt_wb = 0;
        check("step_halt_state", b_state, 3);
        check("step_halt_step_count", b_steps, 1);
        check("step_halt_cycles", b_cycles, 0);

        // load-use stall for two cycles in RUN
        do_reset();
        run = 1; tick(); run = 0;
        tick();
        load_use = 1; tick(); tick(); load_use = 0;
        tick();
        stop = 1; tick(); stop = 0;
        check("load_use_stall_cycles", stall_cnt, 2);
        check("load_use_cycle_count", b_cycles, 5);

        // command collisions
        do_reset();
        stop = 1; tick(); stop = 0;
        check("idle_stop_ignored", b_state, 0);
        run = 1; tick(); run = 0;
        stop = 1; run = 1; tick(); stop = 0; run = 0;
        check("coll_stop_run", b_state, 0);
        run = 1; step = 1; tick(); run = 0; step = 0;
        check("coll_run_step", b_state, 1);
        halt_wb = 1; stop = 1; tick(); halt_wb = 0; stop = 0;
        check("coll_halt_stop", b_state, 3);

        // saturation, then async reset mid-RUN
        do_reset();
        run = 1; tick(); run = 0;
        repeat (20) tick();
        check("sat_small_cycles", s_cycles, 15);
        check("sat_big_cycles", b_cycles, 20);
        #2 reset = 1'b0;
        #1;
        check("async_state", b_state, 0);
        check("async_cycles", b_cycles, 0);
        check("async_small_cycles", s_cycles, 0);
        check("async_pipe_en", b_pipe_en, 0);
        tick(); reset = 1'b1;
        tick();
        check("post_reset_idle", b_state, 0);

        // async reset mid-STEP aborts without counting
        step = 1; tick(); step = 0;
        #2 reset = 1'b0;
        #1;
        check("abort_step_count", b_steps, 0);
        check("abort_step_done", b_done, 0);
        tick(); reset = 1'b1;
        tick();
        check("abort_state", b_state, 0);
        check("abort_step_count_after", b_steps, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_seq_ctrl.md
PIPELINE_SEQ_CTRL -- requirements
Module: pipeline_seq_ctrl

Interface
REQ-001 Parameter: CNT_SZ, default 32, width of the cycle and step counters.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-low reset.
REQ-004 i_run  input  1  debug command pulse: free-run the pipeline.
REQ-005 i_step  input  1  debug command pulse: advance the pipeline exactly one cycle.
REQ-006 i_stop  input  1  debug command pulse: pause the pipeline.
REQ-007 i_halt_wb  input  1  halt instruction present at the MEM/WB register output.
REQ-008 i_load_use  input  1  load-use hazard detected in ID.
REQ-009 o_pc_enable  output  1  PC write enable.
REQ-010 o_if_id_enable  output  1  IF/ID register enable.
REQ-011 o_id_ex_flush  output  1  insert a bubble (zero control lines) into ID/EX.
REQ-012 o_pipe_enable  output  1  enable for the ID/EX, EX/MEM and MEM/WB registers.
REQ-013 o_state  output  2  current state encoding.
REQ-014 o_halted  output  1  high while in HALTED.
REQ-015 o_step_done  output  1  one-cycle pulse after a step cycle completes.
REQ-016 o_cycle_count  output  CNT_SZ  number of cycles the pipeline advanced.
REQ-017 o_step_count  output  CNT_SZ  number of completed single steps.

Function
REQ-018 The FSM SHALL have the states IDLE=2'b00, RUN=2'b01, STEP=2'b10 and HALTED=2'b11, and o_state SHALL equal the state register.
REQ-019 Command priority when pulses coincide SHALL be i_stop > i_run > i_step.
REQ-020 The IDLE transitions SHALL be: i_run -> RUN, else i_step -> STEP, else stay; i_stop in IDLE has no effect.
REQ-021 The RUN transitions SHALL be: i_halt_wb -> HALTED (takes precedence over i_stop), else i_stop -> IDLE, else stay; i_run and i_step in RUN are ignored.
REQ-022 STEP SHALL last exactly one cycle, then go to IDLE, or to HALTED if i_halt_wb=1 in that cycle; commands in STEP are ignored.
REQ-023 HALTED SHALL be exited only by reset; all commands are ignored there.
REQ-024 The active condition SHALL be (state==RUN or state==STEP) and i_halt_wb==0; it is combinational from state and inputs.
REQ-025 When active and i_load_use=0, o_pc_enable, o_if_id_enable and o_pipe_enable SHALL be 1 and o_id_ex_flush SHALL be 0.
REQ-026 When active and i_load_use=1, o_pc_enable=0, o_if_id_enable=0, o_pipe_enable=1 and o_id_ex_flush=1, so one bubble is inserted per hazard cycle.
REQ-027 When not active, all four enable/flush outputs SHALL be 0, so every pipeline register holds its value.
REQ-028 When i_halt_wb=1, the enables SHALL drop in that same cycle, so the halted instruction is never overwritten in MEM/WB.
REQ-029 o_cycle_count SHALL increment by 1 on each edge where the active condition holds (stall cycles included), and SHALL saturate at all-ones.
REQ-030 o_step_count SHALL increment by 1, wrapping modulo 2^CNT_SZ, on the edge that leaves STEP, including a STEP -> HALTED exit.
REQ-031 o_step_done SHALL be registered and high for exactly the one cycle after the STEP cycle.
REQ-032 o_halted SHALL be registered and equal (state==HALTED).
REQ-033 A one-cycle i_run pulse SHALL give RUN from the next edge onward; RUN needs no held level.

Reset
REQ-034 While i_reset=0, the block SHALL immediately and asynchronously force state=IDLE, o_cycle_count=0, o_step_count=0, o_step_done=0 and o_halted=0.
REQ-035 During reset, all enables and o_id_ex_flush SHALL be 0 and o_state SHALL be 2'b00.
REQ-036 Reset asserted mid-RUN or mid-STEP SHALL abort with no counter increment; after deassertion the block waits in IDLE for a command.

Verification
REQ-037 Scenario, run then stop: release reset, pulse i_run, wait 10 cycles, pulse i_stop -> enables high for exactly 10 cycles, state back to 2'b00, o_cycle_count=10.
REQ-038 Scenario, three steps: from IDLE, pulse i_step three times with gaps -> three single-cycle enable windows, three o_step_done pulses, o_step_count=3, o_cycle_count=3.
REQ-039 Scenario, halt: in RUN, assert i_halt_wb -> enables 0 in that cycle, next cycle o_halted=1 and o_state=2'b11; later i_run and i_step produce no enable.
REQ-040 Scenario, load-use: in RUN, hold i_load_use high for 2 cycles -> o_pc_enable=o_if_id_enable=0, o_id_ex_flush=1 and o_pipe_enable=1 for exactly 2 cycles; o_cycle_count counts them.
REQ-041 Scenario, command collisions: pulse i_stop and i_run together in RUN -> IDLE; pulse i_run and i_step together in IDLE -> RUN; i_halt_wb with i_stop in RUN -> HALTED.
REQ-042 Scenario, async reset and saturation: drop i_reset between clock edges during RUN -> outputs clear without waiting for an edge; with CNT_SZ=4, run 20 cycles -> o_cycle_count holds at 15.
